// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, branch, jump, call/return with a circular return-address stack.
// Optional build macro PC_RELATIVE_BRANCH_EN makes branch targets pc-relative (sign-extended offset).
module pc_sequencer #(
  parameter int                ADDR_W       = 72,
  parameter int                JUMP_W       = 55,
  parameter int                BRANCH_W     = 68,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         branch_en,
  input  logic                         alu_flag,
  input  logic                         jump_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [JUMP_W-1:0]            jump_address,
  input  logic [BRANCH_W-1:0]          branch_address,
  output logic [ADDR_W-1:0]            pc_out,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ras_ptr_dec;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full;
  logic              ras_empty;
  logic              branch_taken;
  logic              push_fire;

  assign pc_inc       = pc_out + ADDR_W'(1);
  assign jump_target  = ADDR_W'(jump_address);
  assign branch_taken = branch_en & alu_flag;

`ifdef PC_RELATIVE_BRANCH_EN
  assign branch_target = pc_out + ADDR_W'($signed(branch_address));
`else
  assign branch_target = ADDR_W'(branch_address);
`endif

  // ras_ptr is the next free slot; the top of stack sits one below it.
  assign ras_ptr_dec = ras_ptr - PTR_W'(1);
  assign ras_top     = ras_mem[ras_ptr_dec];
  assign ras_full    = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty   = (ras_count == '0);
  assign push_fire   = !rst && !stall && !ret_en && call_en;

  // Stack storage carries no reset; ras_count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      ras_mem[ras_ptr] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_VECTOR;
      redirect      <= 1'b0;
      ras_count     <= '0;
      ras_ptr       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
    end else if (ret_en) begin
      if (!ras_empty) begin
        pc_out    <= ras_top;
        redirect  <= 1'b1;
        ras_ptr   <= ras_ptr_dec;
        ras_count <= ras_count - CNT_W'(1);
      end else begin
        pc_out        <= pc_inc;
        redirect      <= 1'b0;
        ras_underflow <= 1'b1;
      end
    end else if (call_en) begin
      pc_out   <= jump_target;
      redirect <= 1'b1;
      ras_ptr  <= ras_ptr + PTR_W'(1);
      // A full stack wraps onto its oldest entry, so the count saturates.
      if (ras_full) begin
        ras_overflow <= 1'b1;
      end else begin
        ras_count <= ras_count + CNT_W'(1);
      end
    end else if (jump_en) begin
      pc_out   <= jump_target;
      redirect <= 1'b1;
    end else if (branch_taken) begin
      pc_out   <= branch_target;
      redirect <= 1'b1;
    end else begin
      pc_out   <= pc_inc;
      redirect <= 1'b0;
    end
  end

endmodule
